// File: rtl/uart_tx_arbiter_pkg.sv
// uart_tx_arbiter_pkg
//   Shared definitions for the UART transmit arbiter slice: FSM state
//   encoding and default sizing. Imported by the arbiter top and rr_pick.
package uart_tx_arbiter_pkg;

   localparam int DEF_NUM_REQ = 4;
   localparam int DEF_DATA_W  = 32;
   // Must exceed one full serializer frame time, otherwise good transfers abort.
   localparam int DEF_TIMEOUT = 4096;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } arbState_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick
//   Combinational round-robin picker. Scans req starting one above lastIdx,
//   wrapping at NUM_REQ, and returns the first asserted index.
// Ports:
//   req     in   NUM_REQ  request vector
//   lastIdx in   IDX_W    index granted most recently (lowest priority now)
//   winner  out  IDX_W    chosen index (0 when valid is low)
//   valid   out  1        at least one request present
module rr_pick import uart_tx_arbiter_pkg::*; #(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   lastIdx,
   output logic [IDX_W-1:0]   winner,
   output logic               valid
);

   // cand[k] is the index holding priority rank k (0 = highest).
   logic [NUM_REQ-1:0][IDX_W-1:0] cand;

   for (genvar k = 0; k < NUM_REQ; k++) begin : gCand
      assign cand[k] = IDX_W'((int'(lastIdx) + k + 1) % NUM_REQ);
   end

   // Walk from lowest to highest priority so the last hit written wins;
   // avoids an early-exit loop.
   always_comb begin
      winner = '0;
      valid  = 1'b0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (req[cand[k]]) begin
            winner = cand[k];
            valid  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one UART serializer between NUM_REQ requesters. Round-robin picks
//   a winner in IDLE, latches its word, pulses tx_start, waits for tx_done
//   (or the watchdog) and then acks the winner. All outputs are registered.
// Ports:
//   clk          in   1               system clock, rising edge
//   rst_n        in   1               async active-low reset
//   req          in   NUM_REQ         level requests, held until ack
//   req_data     in   NUM_REQ*DATA_W  flattened words, slice i = requester i
//   grant        out  NUM_REQ         one-hot, requester whose word is in flight
//   ack          out  NUM_REQ         one-hot one-cycle pulse, word transmitted
//   timeout_err  out  1               one-cycle pulse, transfer aborted
//   busy         out  1               high outside IDLE
//   tx_start     out  1               one-cycle start pulse to serializer
//   tx_data      out  DATA_W          latched word to serializer
//   tx_done      in   1               serializer end-of-frame, used only in WAIT
module uart_tx_arbiter import uart_tx_arbiter_pkg::*; #(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        grant,
   output logic [NUM_REQ-1:0]        ack,
   output logic                      timeout_err,
   output logic                      busy,
   output logic                      tx_start,
   output logic [DATA_W-1:0]         tx_data,
   input  logic                      tx_done
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

   arbState_t                     state, stateNxt;
   logic [IDX_W-1:0]              lastIdx, lastIdxNxt;
   logic [IDX_W-1:0]              winIdx, winIdxNxt;
   logic [CNT_W-1:0]              waitCnt, waitCntNxt;
   logic [NUM_REQ-1:0]            grantNxt, ackNxt;
   logic                          timeoutErrNxt, busyNxt, txStartNxt;
   logic [DATA_W-1:0]             txDataNxt;
   logic [IDX_W-1:0]              pickIdx;
   logic                          pickValid;
   logic [NUM_REQ-1:0][DATA_W-1:0] reqWord;

   // Same bit layout as the flat port: reqWord[i] == slice i.
   assign reqWord = req_data;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) uPick (
      .req     (req),
      .lastIdx (lastIdx),
      .winner  (pickIdx),
      .valid   (pickValid)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         lastIdx     <= IDX_W'(NUM_REQ - 1);
         winIdx      <= '0;
         waitCnt     <= '0;
         grant       <= '0;
         ack         <= '0;
         timeout_err <= 1'b0;
         busy        <= 1'b0;
         tx_start    <= 1'b0;
         tx_data     <= '0;
      end else begin
         state       <= stateNxt;
         lastIdx     <= lastIdxNxt;
         winIdx      <= winIdxNxt;
         waitCnt     <= waitCntNxt;
         grant       <= grantNxt;
         ack         <= ackNxt;
         timeout_err <= timeoutErrNxt;
         busy        <= busyNxt;
         tx_start    <= txStartNxt;
         tx_data     <= txDataNxt;
      end
   end

   // Outputs are registered, so each state computes the values seen during
   // the following state: tx_start is high in the first WAIT cycle, and
   // ack / timeout_err are high during DONE. Abort is decided on the WAIT
   // exit edge, so no separate abort flag needs to be carried into DONE.
   always_comb begin
      stateNxt      = state;
      lastIdxNxt    = lastIdx;
      winIdxNxt     = winIdx;
      waitCntNxt    = waitCnt;
      grantNxt      = grant;
      ackNxt        = '0;
      timeoutErrNxt = 1'b0;
      busyNxt       = busy;
      txStartNxt    = 1'b0;
      txDataNxt     = tx_data;
      unique case (state)
         IDLE: begin
            if (pickValid) begin
               winIdxNxt = pickIdx;
               txDataNxt = reqWord[pickIdx];
               grantNxt  = NUM_REQ'(1) << pickIdx;
               busyNxt   = 1'b1;
               stateNxt  = START;
            end
         end
         START: begin
            txStartNxt = 1'b1;
            waitCntNxt = '0;
            stateNxt   = WAIT;
         end
         WAIT: begin
            // tx_done is checked first so a coincident timeout is not an error.
            if (tx_done) begin
               ackNxt   = grant;
               stateNxt = DONE;
            end else if (waitCnt == CNT_MAX) begin
               timeoutErrNxt = 1'b1;
               stateNxt      = DONE;
            end else begin
               waitCntNxt = waitCnt + 1'b1;
            end
         end
         DONE: begin
            // An aborted winner also becomes lowest priority, so it retries
            // only after the others have had their turn.
            grantNxt   = '0;
            busyNxt    = 1'b0;
            lastIdxNxt = winIdx;
            stateNxt   = IDLE;
         end
         default: stateNxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
//   Randomized + directed bench for uart_tx_arbiter. The reference model is
//   transaction level: a round-robin pick over the currently held requests,
//   the word each requester presented, and the cycle timing of one transfer.
module tb_uart_tx_arbiter;

   localparam int NUM_REQ = 4;
   localparam int DATA_W  = 32;
   localparam int TIMEOUT = 64;

   typedef logic [1:0] idx_t;

   logic                            clk = 1'b0;
   logic                            rst_n = 1'b0;
   logic                            tx_done = 1'b0;
   logic [NUM_REQ-1:0]              req = '0;
   logic [NUM_REQ-1:0][DATA_W-1:0]  reqDataArr = '0;
   logic [NUM_REQ-1:0]              grant, ack;
   logic                            timeout_err, busy, tx_start;
   logic [DATA_W-1:0]               tx_data;

   int checks = 0;
   int failures = 0;

   // Reference model state
   logic [DATA_W-1:0] mWord [NUM_REQ];
   int                mLast;

   always #5 clk = ~clk;

   uart_tx_arbiter #(
      .NUM_REQ (NUM_REQ),
      .DATA_W  (DATA_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req),
      .req_data    (reqDataArr),
      .grant       (grant),
      .ack         (ack),
      .timeout_err (timeout_err),
      .busy        (busy),
      .tx_start    (tx_start),
      .tx_data     (tx_data),
      .tx_done     (tx_done)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic setReq(input int i, input logic [DATA_W-1:0] w);
      req                  = req | (NUM_REQ'(1) << i);
      reqDataArr[idx_t'(i)] = w;
      mWord[idx_t'(i)]     = w;
   endtask

   task automatic dropReq(input int i);
      req = req & ~(NUM_REQ'(1) << i);
   endtask

   // Round-robin: first held request after the last winner, wrapping.
   function automatic int mPick();
      for (int k = 1; k <= NUM_REQ; k++) begin
         int i;
         i = (mLast + k) % NUM_REQ;
         if (req[idx_t'(i)]) return i;
      end
      return -1;
   endfunction

   // One full transfer. Called at a negedge with the DUT in IDLE and at
   // least one request held. d = cycles from tx_start to the edge that
   // samples tx_done (1..TIMEOUT), 0 = serializer never answers.
   task automatic doXfer(input int d, input bit dropAfter, input bit dropMid, input bit wiggle);
      int                 w, lat, k;
      bit                 abrt;
      logic [NUM_REQ-1:0] g;
      logic [DATA_W-1:0]  exp, nw;
      w   = mPick();
      exp = mWord[idx_t'(w)];
      g   = NUM_REQ'(1) << w;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (grant == '0 && lat < 20);
      chk("grantLatency", 32'(lat), 32'd1);
      chk("grant", 32'(grant), 32'(g));
      chk("txDataLatched", tx_data, exp);
      chk("busyInXfer", 32'(busy), 32'd1);
      chk("txStartEarly", 32'(tx_start), 32'd0);
      if (wiggle) begin
         nw = $urandom;
         reqDataArr[idx_t'(w)] = nw;
         mWord[idx_t'(w)]      = nw;
      end
      @(negedge clk);
      chk("txStart", 32'(tx_start), 32'd1);
      chk("txDataHold", tx_data, exp);
      k    = 1;
      abrt = 1'b0;
      forever begin
         if (k > 1) chk("txStartOnce", 32'(tx_start), 32'd0);
         chk("ackEarly", 32'(ack), 32'd0);
         chk("timeoutEarly", 32'(timeout_err), 32'd0);
         if (k == d) begin
            tx_done = 1'b1;
            break;
         end
         if (k == TIMEOUT) begin
            abrt = 1'b1;
            break;
         end
         if (dropMid && k == 2) dropReq(w);
         @(negedge clk);
         k++;
      end
      @(negedge clk);
      tx_done = 1'b0;
      chk("ack", 32'(ack), abrt ? 32'd0 : 32'(g));
      chk("timeoutErr", 32'(timeout_err), 32'(abrt));
      chk("grantInDone", 32'(grant), 32'(g));
      chk("txDataDone", tx_data, exp);
      mLast = w;
      if (!abrt && dropAfter) dropReq(w);
      @(negedge clk);
      chk("idleBusy", 32'(busy), 32'd0);
      chk("idleGrant", 32'(grant), 32'd0);
      chk("idleAck", 32'(ack), 32'd0);
      chk("idleTimeout", 32'(timeout_err), 32'd0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog simulation did not complete checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int d;
      mLast = NUM_REQ - 1;
      for (int i = 0; i < NUM_REQ; i++) mWord[i] = '0;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rstGrant", 32'(grant), 32'd0);
      chk("rstAck", 32'(ack), 32'd0);
      chk("rstBusy", 32'(busy), 32'd0);
      chk("rstTxStart", 32'(tx_start), 32'd0);
      chk("rstTimeout", 32'(timeout_err), 32'd0);
      chk("rstTxData", tx_data, 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("idleNoReq", 32'(busy), 32'd0);

      // Single requester
      setReq(0, 32'hAA0FCC55);
      doXfer(40, 1'b1, 1'b0, 1'b0);

      // After reset, 1010 -> requester 1 then 3
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      mLast = NUM_REQ - 1;
      setReq(1, $urandom);
      setReq(3, $urandom);
      doXfer(10, 1'b1, 1'b0, 1'b0);
      doXfer(10, 1'b1, 1'b0, 1'b0);

      // All four held continuously
      for (int i = 0; i < NUM_REQ; i++) setReq(i, $urandom);
      repeat (5) doXfer(10, 1'b0, 1'b0, 1'b0);
      req = '0;

      // Watchdog abort, then the other requester, then done on the timeout edge
      setReq(0, $urandom);
      setReq(1, $urandom);
      doXfer(0, 1'b1, 1'b0, 1'b0);
      doXfer(5, 1'b1, 1'b0, 1'b0);
      doXfer(TIMEOUT, 1'b1, 1'b0, 1'b0);

      // Shortest wait
      setReq(2, $urandom);
      doXfer(1, 1'b1, 1'b0, 1'b0);

      // Latched word survives req_data change and mid-transfer req drop
      setReq(3, 32'hFF00FF00);
      doXfer(20, 1'b1, 1'b1, 1'b1);

      // tx_done in IDLE is ignored
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
      repeat (2) @(negedge clk);
      chk("idleDoneBusy", 32'(busy), 32'd0);
      chk("idleDoneGrant", 32'(grant), 32'd0);
      chk("idleDoneAck", 32'(ack), 32'd0);
      chk("idleDoneStart", 32'(tx_start), 32'd0);
      chk("idleDoneData", tx_data, 32'hFF00FF00);

      // Reset during WAIT
      for (int i = 0; i < NUM_REQ; i++) setReq(i, $urandom);
      repeat (6) @(negedge clk);
      chk("busyBeforeRst", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("asyncRstGrant", 32'(grant), 32'd0);
      chk("asyncRstBusy", 32'(busy), 32'd0);
      chk("asyncRstData", tx_data, 32'd0);
      chk("asyncRstStart", 32'(tx_start), 32'd0);
      chk("asyncRstAck", 32'(ack), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      mLast = NUM_REQ - 1;
      doXfer(8, 1'b1, 1'b0, 1'b0);
      req = '0;

      // Randomized traffic
      repeat (40) begin
         for (int i = 0; i < NUM_REQ; i++)
            if (!req[idx_t'(i)] && $urandom_range(0, 2) == 0) setReq(i, $urandom);
         if (req == '0) setReq(int'($urandom_range(0, NUM_REQ - 1)), $urandom);
         d = ($urandom_range(0, 11) == 0) ? 0 : int'($urandom_range(1, TIMEOUT));
         doXfer(d, 1'b1, $urandom_range(0, 4) == 0, $urandom_range(0, 1) == 1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
